// File: rtl/timer_ctrl.sv
// Sequences a downstream down-counter to build a one-shot / auto-reload period timer.
// Latency: start accepted in cycle t -> LOAD at t+1, RUN at t+2, done pulse at t+P+1.
// Backpressure: none; start is ignored while busy, stop aborts LOAD/RUN immediately.
module timer_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] count_value,
  output logic             load,
  output logic             up_not_down,
  output logic [WIDTH-1:0] load_value,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] done_count,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_per;
  logic             r_auto;
  logic [CNT_W-1:0] r_done_count;
  logic             r_err;

  logic             w_accept;
  logic             w_bad_start;
  logic             w_load;
  logic             w_done;
  logic [WIDTH-1:0] w_load_value;
  logic [WIDTH-1:0] w_per_m1;

  // Reload value: the counter reaches 0 after P-1 decrements, so a period spans P cycles.
  assign w_per_m1 = r_per - WIDTH'(1);

  // Next-state and Mealy output decode; stop overrides every other event.
  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b1;
    w_load_value = '0;
    w_done       = 1'b0;
    w_accept     = 1'b0;
    w_bad_start  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Counter has no enable, so it is held at 0 by loading continuously.
        if (start && !stop) begin
          if (period == '0) begin
            w_bad_start = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_load_value = w_per_m1;
          w_state_nxt  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (count_value == '0) begin
          w_done = 1'b1;
          if (r_auto) begin
            // Reload in the terminal cycle so consecutive periods have no gap.
            w_load_value = w_per_m1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_load = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, captured run parameters, completion counter and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_per        <= '0;
      r_auto       <= 1'b0;
      r_done_count <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_per        <= period;
        r_auto       <= auto_reload;
        r_done_count <= '0;
        r_err        <= 1'b0;
      end else if (w_done) begin
        r_done_count <= r_done_count + CNT_W'(1);
      end
      if (w_bad_start) begin
        r_err <= 1'b1;
      end
    end
  end

  assign load        = w_load;
  assign load_value  = w_load_value;
  assign done        = w_done;
  assign up_not_down = 1'b0;
  assign busy        = (r_state != ST_IDLE);
  assign done_count  = r_done_count;
  assign err         = r_err;

endmodule
